// File: rtl/seq_divider_8.sv
// Sequential restoring divider: one quotient bit per cycle through a WIDTH+1-bit subtract stage.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating quotient, remainder follows dividend).
module seq_divider_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             zero_divisor;
    logic             last_step;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             carry;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    // The partial remainder is always below the divisor, so its top bit never feeds the next trial.
    logic             unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    assign accept       = (state == IDLE) && start;
    assign zero_divisor = (divisor == '0);
    assign last_step    = (cnt == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo_q;
    logic neg_rem_q;

    assign dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign quo_final    = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
    assign rem_final    = neg_rem_q ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_q <= dividend[WIDTH-1];
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign quo_final    = quo_step;
    assign rem_final    = rem_step[WIDTH-1:0];
`endif

    // Subtract stage A + ~B + 1; carry-out high means no borrow, i.e. trial >= divisor.
    always_comb begin
        trial            = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        {carry, diff}    = {1'b0, trial} + {1'b0, ~{1'b0, div_q}} + {{(WIDTH + 1){1'b0}}, 1'b1};
        rem_step         = carry ? diff : trial;
        quo_step         = {quo_q[WIDTH-2:0], carry};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_divisor ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE:    busy = 1'b0;
            RUN:     busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (zero_divisor) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end else begin
                            rem_q    <= '0;
                            quo_q    <= dividend_mag;
                            div_q    <= divisor_mag;
                            cnt      <= CNT_LAST;
                            div_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt   <= cnt - 1'b1;
                    // Results (with any sign fix-up) land on the edge that enters DONE.
                    if (last_step) begin
                        quotient  <= quo_final;
                        remainder <= rem_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_8.sv
// Directed and random checks for seq_divider_8: reset, results, latency, ignored starts, mid-op reset.
module tb_seq_divider_8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    seq_divider_8 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation; cycle 1 is the cycle after the accepting edge.
    // A start with 50/5 is pulsed in cycle inject_at (0 = none) and must be ignored.
    task automatic do_op(input string name, input logic [7:0] dd, input logic [7:0] dv,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez,
                         input int elat, input int inject_at);
        int k;
        int lat;
        bit got;
        bit busy_ok;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        tick();
        start   = 1'b0;
        k       = 1;
        got     = 1'b0;
        busy_ok = 1'b1;
        while (k <= 20 && !got) begin
            if (k == inject_at) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                tick();
                k++;
            end
        end
        start = 1'b0;
        lat   = got ? k : 0;

        total_cnt++;
        if (lat !== elat) $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, elat);
        else pass_cnt++;
        total_cnt++;
        if (busy_ok !== 1'b1) $display("FAIL %s busy: dropped before done", name);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== eq) $display("FAIL %s quotient: got %h, expected %h", name, quotient, eq);
        else pass_cnt++;
        total_cnt++;
        if (remainder !== er) $display("FAIL %s remainder: got %h, expected %h", name, remainder, er);
        else pass_cnt++;
        total_cnt++;
        if (div_zero !== ez) $display("FAIL %s div_zero: got %b, expected %b", name, div_zero, ez);
        else pass_cnt++;

        tick();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s after_done: done=%b busy=%b, expected 0 0", name, done, busy);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== eq || remainder !== er)
            $display("FAIL %s hold: got %h r %h, expected %h r %h", name, quotient, remainder, eq, er);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        tick();
        tick();
        total_cnt++;
        if ({busy, done, div_zero} !== 3'b000)
            $display("FAIL reset flags: busy=%b done=%b div_zero=%b, expected 0 0 0", busy, done, div_zero);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 8'h00 || remainder !== 8'h00)
            $display("FAIL reset results: got %h r %h, expected 00 r 00", quotient, remainder);
        else pass_cnt++;
        start = 1'b0;
        rst   = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_op("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 0);
    endtask

    task automatic test_boundary();
        do_op("255/1", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9, 0);
        do_op("3/200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 9, 0);
    endtask

    task automatic test_div_zero();
        do_op("5/0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1, 0);
        do_op("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, 0);
    endtask

    task automatic test_ignored_start();
        do_op("100/7_inject_run", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 3);
        do_op("100/7_inject_done", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 9);
    endtask

    task automatic test_reset_mid_op();
        bit saw_done;
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, div_zero} !== 3'b000 || quotient !== 8'h00 || remainder !== 8'h00)
            $display("FAIL mid_reset outputs: busy=%b done=%b dz=%b q=%h r=%h, expected all 0",
                     busy, done, div_zero, quotient, remainder);
        else pass_cnt++;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            tick();
        end
        total_cnt++;
        if (saw_done !== 1'b0) $display("FAIL mid_reset abandon: activity seen after reset, expected none");
        else pass_cnt++;
        do_op("50/5_after_reset", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9, 0);
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed();
        do_op("-100/7", 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 9, 0);
        do_op("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9, 0);
        do_op("100/-7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 9, 0);
        do_op("-7/0", 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1, 1, 0);
    endtask
`else
    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        int         recon;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            do_op("random", a, b, a / b, a % b, 1'b0, 9, 0);
            recon = int'(quotient) * int'(b) + int'(remainder);
            total_cnt++;
            if (recon !== int'(a) || remainder >= b)
                $display("FAIL invariant %0d/%0d: q=%0d r=%0d", a, b, quotient, remainder);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_ignored_start();
        test_reset_mid_op();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`else
        test_random();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
